// File: rtl/scan_sched_pkg.sv
// Package: scan_sched_pkg
// Shared definitions for the ping-pong scanner buffer scheduler:
//   - scan FSM state encoding
//   - default counter width, full depth and flush threshold
//   - buffer index constants
package scan_sched_pkg;

   localparam int unsigned CW_DEF           = 8;
   localparam int unsigned DEPTH_DEF        = 100;
   localparam int unsigned FLUSH_THRESH_DEF = 50;

   localparam int unsigned BUF0 = 0;
   localparam int unsigned BUF1 = 1;

   // S_WAITk means "waiting to fill buffer k".
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL0 = 3'd1,
      S_FILL1 = 3'd2,
      S_WAIT0 = 3'd3,
      S_WAIT1 = 3'd4
   } scan_state_t;

   // One-hot fill enable implied by a scan state.
   function automatic logic [1:0] fill_onehot(input scan_state_t s);
      case (s)
         S_FILL0: fill_onehot = 2'b01;
         S_FILL1: fill_onehot = 2'b10;
         default: fill_onehot = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/xfer_rr_arb.sv
// Module: xfer_rr_arb
// Two-way round-robin arbiter for the single outbound transfer link.
// A grant is issued only while the link is idle and the host is ready, and is
// held until the granted buffer reports empty. The grant drops for at least one
// cycle before the next one, because a new grant is only considered while the
// registered grant is zero.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset (rr_last -> 1)
//   i_ready[1:0] in   buffer k full and available for transfer
//   i_done[1:0]  in   buffer k count is zero
//   i_host_ready in   link can accept a new transfer
//   o_grant[1:0] out  registered one-hot grant
//   o_grant_nxt  out  value o_grant takes at the next edge
module xfer_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_ready,
   input  logic [1:0] i_done,
   input  logic       i_host_ready,
   output logic [1:0] o_grant,
   output logic [1:0] o_grant_nxt
);

   logic [1:0] r_grant;
   logic       r_rr_last;
   logic [1:0] w_grant_nxt;
   logic       w_rr_last_nxt;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_grant_nxt   = r_grant;
      w_rr_last_nxt = r_rr_last;
      if (r_grant != 2'b00) begin
         // host_ready is ignored here: a running transfer is never revoked.
         if ((r_grant & i_done) != 2'b00) w_grant_nxt = 2'b00;
      end else if (i_host_ready) begin
         case (i_ready)
            2'b01: w_grant_nxt = 2'b01;
            2'b10: w_grant_nxt = 2'b10;
            2'b11: begin
               // Contention: serve the buffer not served last time.
               w_grant_nxt   = r_rr_last ? 2'b01 : 2'b10;
               w_rr_last_nxt = ~r_rr_last;
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant   <= 2'b00;
         r_rr_last <= 1'b1;
      end else begin
         r_grant   <= w_grant_nxt;
         r_rr_last <= w_rr_last_nxt;
      end
   end

   assign o_grant     = r_grant;
   assign o_grant_nxt = w_grant_nxt;

endmodule

// File: rtl/scan_buffer_sched.sv
// Module: scan_buffer_sched
// Controller for the dual ping-pong scanner buffers. Chooses which buffer is
// being filled, grants the outbound transfer link through xfer_rr_arb, and
// flushes the filling buffer when it fills while the other one is still
// largely occupied. All outputs are registered.
// Optional feature: define SCAN_SCHED_STATS_EN to add a saturating flush_cnt.
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   scan_req          level, scanning requested
//   host_ready        level, link can accept a new transfer
//   cnt0, cnt1 [CW]   buffer data counts
//   scan_en  [1:0]    one-hot fill enable
//   xfer_en  [1:0]    one-hot transfer grant
//   flush    [1:0]    one-cycle flush pulse
//   overrun           sticky flush indicator
//   busy              FSM not idle or link granted
//   flush_cnt [15:0]  (SCAN_SCHED_STATS_EN only) saturating flush count
module scan_buffer_sched
   import scan_sched_pkg::*;
#(
   parameter int unsigned CW           = CW_DEF,
   parameter int unsigned DEPTH        = DEPTH_DEF,
   parameter int unsigned FLUSH_THRESH = FLUSH_THRESH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scan_req,
   input  logic          host_ready,
   input  logic [CW-1:0] cnt0,
   input  logic [CW-1:0] cnt1,
   output logic [1:0]    scan_en,
   output logic [1:0]    xfer_en,
   output logic [1:0]    flush,
   output logic          overrun,
   output logic          busy
`ifdef SCAN_SCHED_STATS_EN
   ,output logic [15:0]  flush_cnt
`endif
);

   localparam logic [CW-1:0] L_DEPTH  = CW'(DEPTH);
   localparam logic [CW-1:0] L_THRESH = CW'(FLUSH_THRESH);

   scan_state_t r_state, w_state_nxt;
   logic [1:0]  r_scan_en, r_flush;
   logic        r_overrun, r_busy;
   logic [1:0]  w_scan_nxt, w_flush_nxt;
   logic [1:0]  w_grant, w_grant_nxt, w_ready, w_done;

   // Owner/other selection for the FILL states, and target for the WAIT states.
   logic          w_fill_idx, w_wait_idx;
   logic [CW-1:0] w_cnt_own, w_cnt_oth, w_cnt_wait;
   logic          w_oth_free, w_wait_free;

   assign w_fill_idx  = (r_state == S_FILL1);
   assign w_wait_idx  = (r_state == S_WAIT1);
   assign w_cnt_own   = w_fill_idx ? cnt1 : cnt0;
   assign w_cnt_oth   = w_fill_idx ? cnt0 : cnt1;
   assign w_cnt_wait  = w_wait_idx ? cnt1 : cnt0;
   // A buffer may start filling only once it is empty and off the link.
   assign w_oth_free  = (w_cnt_oth == '0) && !(w_fill_idx ? w_grant[0] : w_grant[1]);
   assign w_wait_free = (w_cnt_wait == '0) && !(w_wait_idx ? w_grant[1] : w_grant[0]);

   always_comb begin
      w_state_nxt = r_state;
      w_flush_nxt = 2'b00;
      case (r_state)
         S_IDLE: if (scan_req) w_state_nxt = S_FILL0;
         S_FILL0, S_FILL1: begin
            // While the flush pulse is out the count has not cleared yet;
            // skip that cycle so the pulse stays one cycle wide.
            if (w_cnt_own >= L_DEPTH && !r_flush[w_fill_idx]) begin
               if (w_cnt_oth >= L_THRESH)
                  w_flush_nxt[w_fill_idx] = 1'b1;
               else if (w_oth_free)
                  w_state_nxt = !scan_req ? S_IDLE : (w_fill_idx ? S_FILL0 : S_FILL1);
               else
                  w_state_nxt = w_fill_idx ? S_WAIT0 : S_WAIT1;
            end
         end
         S_WAIT0, S_WAIT1: begin
            if (w_wait_free)
               w_state_nxt = !scan_req ? S_IDLE : (w_wait_idx ? S_FILL1 : S_FILL0);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_scan_nxt = fill_onehot(w_state_nxt);

   // Readiness looks at next-cycle scan/flush so a buffer handed off this edge
   // is granted in the same cycle the fill moves away, and never collides.
   assign w_ready[0] = (cnt0 >= L_DEPTH) && !w_scan_nxt[0] && !w_flush_nxt[0];
   assign w_ready[1] = (cnt1 >= L_DEPTH) && !w_scan_nxt[1] && !w_flush_nxt[1];
   assign w_done[0]  = (cnt0 == '0);
   assign w_done[1]  = (cnt1 == '0);

   xfer_rr_arb u_arb (
      .clk          (clk),
      .rst          (rst),
      .i_ready      (w_ready),
      .i_done       (w_done),
      .i_host_ready (host_ready),
      .o_grant      (w_grant),
      .o_grant_nxt  (w_grant_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_scan_en <= 2'b00;
         r_flush   <= 2'b00;
         r_overrun <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_scan_en <= w_scan_nxt;
         r_flush   <= w_flush_nxt;
         r_overrun <= r_overrun | (|w_flush_nxt);
         r_busy    <= (w_state_nxt != S_IDLE) || (w_grant_nxt != 2'b00);
      end
   end

   assign scan_en = r_scan_en;
   assign xfer_en = w_grant;
   assign flush   = r_flush;
   assign overrun = r_overrun;
   assign busy    = r_busy;

`ifdef SCAN_SCHED_STATS_EN
   logic [15:0] r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_flush_cnt <= 16'h0000;
      else if (|w_flush_nxt && r_flush_cnt != 16'hFFFF)
         r_flush_cnt <= r_flush_cnt + 16'h0001;
   end

   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_scan_buffer_sched.sv
// Directed testbench for scan_buffer_sched. Inputs change 1 ns after the
// rising edge; outputs are sampled at the same point, i.e. they show the
// result of the edge just taken.
module tb_scan_buffer_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       scan_req;
   logic       host_ready;
   logic [7:0] cnt0, cnt1;
   logic [1:0] scan_en, xfer_en, flush;
   logic       overrun, busy;
`ifdef SCAN_SCHED_STATS_EN
   logic [15:0] flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // {scan_en, xfer_en, flush, overrun, busy}
   logic [7:0] obs;
   assign obs = {scan_en, xfer_en, flush, overrun, busy};

   always #5 clk = ~clk;

   scan_buffer_sched dut (
      .clk        (clk),
      .rst        (rst),
      .scan_req   (scan_req),
      .host_ready (host_ready),
      .cnt0       (cnt0),
      .cnt1       (cnt1),
      .scan_en    (scan_en),
      .xfer_en    (xfer_en),
      .flush      (flush),
      .overrun    (overrun),
      .busy       (busy)
`ifdef SCAN_SCHED_STATS_EN
      ,.flush_cnt (flush_cnt)
`endif
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      scan_req   = 1'b0;
      host_ready = 1'b0;
      cnt0       = 8'd0;
      cnt1       = 8'd0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   // Test 1: reset values, then asynchronous reset while filling buffer 1
   // with buffer 0 on the link.
   task automatic test_reset();
      do_reset();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         errors++;
         $display("FAIL reset_state: outputs=%b expected=%b", obs, 8'b00_00_00_0_0);
      end
      scan_req = 1'b1; host_ready = 1'b1; cnt0 = 8'd100; cnt1 = 8'd0;
      cycle();  // IDLE -> FILL0
      cycle();  // FILL0 full -> FILL1, buffer 0 granted
      checks++;
      if (obs !== 8'b10_01_00_0_1) begin
         errors++;
         $display("FAIL reset_setup: outputs=%b expected=%b", obs, 8'b10_01_00_0_1);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         errors++;
         $display("FAIL reset_async: outputs=%b expected=%b", obs, 8'b00_00_00_0_0);
      end
      scan_req = 1'b0; cnt0 = 8'd0;
      cycle();
      rst = 1'b0;
      cycle();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         errors++;
         $display("FAIL reset_idle: outputs=%b expected=%b", obs, 8'b00_00_00_0_0);
      end
   endtask

   // Test 2: buffer 0 ramps to full, fill swaps to buffer 1 and buffer 0 is
   // granted in the same cycle.
   task automatic test_fill_swap();
      logic [7:0] ramp [5];
      ramp = '{8'd0, 8'd25, 8'd50, 8'd75, 8'd99};
      do_reset();
      scan_req = 1'b1; host_ready = 1'b1;
      cycle();
      checks++;
      if (obs !== 8'b01_00_00_0_1) begin
         errors++;
         $display("FAIL swap_start: outputs=%b expected=%b", obs, 8'b01_00_00_0_1);
      end
      for (int i = 0; i < 5; i++) begin
         cnt0 = ramp[i];
         cycle();
         checks++;
         if (obs !== 8'b01_00_00_0_1) begin
            errors++;
            $display("FAIL swap_ramp cnt0=%0d: outputs=%b expected=%b", ramp[i], obs, 8'b01_00_00_0_1);
         end
      end
      cnt0 = 8'd100;
      cycle();
      checks++;
      if (obs !== 8'b10_01_00_0_1) begin
         errors++;
         $display("FAIL swap_full: outputs=%b expected=%b", obs, 8'b10_01_00_0_1);
      end
   endtask

   // Test 3: buffer 1 fills while buffer 0 still holds 60 -> one-cycle flush.
   task automatic test_flush();
      do_reset();
      scan_req = 1'b1; host_ready = 1'b1;
      cycle();
      cnt0 = 8'd100;
      cycle();                       // FILL1, buffer 0 granted
      cnt0 = 8'd60; cnt1 = 8'd100;
      cycle();
      checks++;
      if (obs !== 8'b10_01_10_1_1) begin
         errors++;
         $display("FAIL flush_pulse: outputs=%b expected=%b", obs, 8'b10_01_10_1_1);
      end
      cnt1 = 8'd0;                   // scanner cleared the flushed buffer
      cycle();
      checks++;
      if (obs !== 8'b10_01_00_1_1) begin
         errors++;
         $display("FAIL flush_end: outputs=%b expected=%b", obs, 8'b10_01_00_1_1);
      end
      cycle();
      checks++;
      if (obs !== 8'b10_01_00_1_1) begin
         errors++;
         $display("FAIL flush_sticky: outputs=%b expected=%b", obs, 8'b10_01_00_1_1);
      end
   endtask

   // Test 4: buffer 1 fills while buffer 0 is mid-transfer at 20 -> WAIT0.
   task automatic test_wait();
      do_reset();
      scan_req = 1'b1; host_ready = 1'b1;
      cycle();
      cnt0 = 8'd100;
      cycle();
      cnt0 = 8'd20; cnt1 = 8'd100;
      cycle();
      checks++;
      if (obs !== 8'b00_01_00_0_1) begin
         errors++;
         $display("FAIL wait_enter: outputs=%b expected=%b", obs, 8'b00_01_00_0_1);
      end
      cnt0 = 8'd0;
      cycle();
      checks++;
      if (obs !== 8'b00_00_00_0_1) begin
         errors++;
         $display("FAIL wait_xfer_drop: outputs=%b expected=%b", obs, 8'b00_00_00_0_1);
      end
      cycle();
      // Fill resumes on buffer 0 while the full buffer 1 takes the link.
      checks++;
      if (obs !== 8'b01_10_00_0_1) begin
         errors++;
         $display("FAIL wait_resume: outputs=%b expected=%b", obs, 8'b01_10_00_0_1);
      end
   endtask

   // Test 5: both buffers full and idle, rr_last=1 after reset.
   task automatic test_rr();
      do_reset();
      host_ready = 1'b1; cnt0 = 8'd100; cnt1 = 8'd100;
      cycle();
      checks++;
      if (obs !== 8'b00_01_00_0_1) begin
         errors++;
         $display("FAIL rr_first: outputs=%b expected=%b", obs, 8'b00_01_00_0_1);
      end
      cnt0 = 8'd50; host_ready = 1'b0;  // host_ready drop must not revoke
      cycle();
      checks++;
      if (obs !== 8'b00_01_00_0_1) begin
         errors++;
         $display("FAIL rr_hold: outputs=%b expected=%b", obs, 8'b00_01_00_0_1);
      end
      cnt0 = 8'd0; host_ready = 1'b1;
      cycle();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         errors++;
         $display("FAIL rr_idle_gap: outputs=%b expected=%b", obs, 8'b00_00_00_0_0);
      end
      cycle();
      checks++;
      if (obs !== 8'b00_10_00_0_1) begin
         errors++;
         $display("FAIL rr_second: outputs=%b expected=%b", obs, 8'b00_10_00_0_1);
      end
   endtask

   // Contention twice in a row: second grant alternates to buffer 1.
   task automatic test_back_to_back();
      do_reset();
      host_ready = 1'b1; cnt0 = 8'd100; cnt1 = 8'd100;
      cycle();
      cnt0 = 8'd0;
      cycle();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         errors++;
         $display("FAIL b2b_gap: outputs=%b expected=%b", obs, 8'b00_00_00_0_0);
      end
      cnt0 = 8'd100;
      cycle();
      checks++;
      if (obs !== 8'b00_10_00_0_1) begin
         errors++;
         $display("FAIL b2b_alternate: outputs=%b expected=%b", obs, 8'b00_10_00_0_1);
      end
   endtask

`ifdef SCAN_SCHED_STATS_EN
   task automatic one_flush();
      cnt0 = 8'd100; cnt1 = 8'd60;
      cycle();
      checks++;
      if (flush !== 2'b01) begin
         errors++;
         $display("FAIL stats_flush: flush=%b expected=%b", flush, 2'b01);
      end
      cnt0 = 8'd0;
      cycle();
   endtask

   task automatic test_stats();
      do_reset();
      scan_req = 1'b1;
      cycle();
      for (int i = 0; i < 3; i++) one_flush();
      checks++;
      if (flush_cnt !== 16'd3) begin
         errors++;
         $display("FAIL stats_count: flush_cnt=%0d expected=%0d", flush_cnt, 3);
      end
      force dut.r_flush_cnt = 16'hFFFF;
      #1;
      release dut.r_flush_cnt;
      one_flush();
      checks++;
      if (flush_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL stats_saturate: flush_cnt=%h expected=%h", flush_cnt, 16'hFFFF);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_swap();
      test_flush();
      test_wait();
      test_rr();
      test_back_to_back();
`ifdef SCAN_SCHED_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
